// File: rtl/wb_boot_copier.sv
// Wishbone initiator that copies a block of 32-bit words from src to dst,
// one single classic-cycle read then write per word, with per-transaction timeout.
module wb_boot_copier #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned GAP_CYCLES     = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] src_addr_i,
  input  logic [31:0] dst_addr_i,
  input  logic [19:0] len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [19:0] words_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_addr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_data_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_data_i
);

  typedef enum logic [2:0] {IDLE, RD, RD_GAP, WR, WR_GAP, DONE, ERR} state_t;

  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] data_q, data_d;
  logic [19:0] rem_q, rem_d;
  logic [19:0] words_q, words_d;
  logic [15:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      words_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      words_q <= words_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    rem_d   = rem_q;
    words_d = words_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d   = src_addr_i & ~32'h3;
          dst_d   = dst_addr_i & ~32'h3;
          rem_d   = len_i;
          words_d = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = (len_i == '0) ? DONE : RD;
        end
      end
      RD: begin
        // An ack in the limit cycle takes priority over the timeout.
        if (wb_ack_i) begin
          data_d  = wb_data_i;
          state_d = RD_GAP;
        end else if (cnt_q == TO_LAST) begin
          state_d = ERR;
        end
      end
      RD_GAP: if (cnt_q == GAP_LAST) state_d = WR;
      WR: begin
        if (wb_ack_i) begin
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          words_d = words_q + 20'd1;
          rem_d   = rem_q - 20'd1;
          state_d = (rem_q == 20'd1) ? DONE : WR_GAP;
        end else if (cnt_q == TO_LAST) begin
          state_d = ERR;
        end
      end
      WR_GAP: if (cnt_q == GAP_LAST) state_d = RD;
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      ERR: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // One counter serves both the request timeout and the gap length.
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 16'd1;
  end

  assign wb_cyc_o  = (state_q == RD) || (state_q == WR);
  assign wb_stb_o  = wb_cyc_o;
  assign wb_we_o   = (state_q == WR);
  assign wb_addr_o = (state_q == RD) ? src_q : (state_q == WR) ? dst_q : '0;
  assign wb_sel_o  = wb_cyc_o ? 4'b1111 : 4'b0000;
  assign wb_data_o = data_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign words_o   = words_q;

endmodule

// File: tb/tb_wb_boot_copier.sv
// Randomised scoreboard bench for wb_boot_copier: expected bus transactions and
// completions are queued by a word-level copy model and checked by a bus monitor.
module tb_wb_boot_copier;

  localparam int unsigned TO  = 64;
  localparam int unsigned GAP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src, dst;
  logic [19:0] len;
  logic        busy, done, err;
  logic [19:0] words;
  logic        wb_cyc, wb_stb, wb_we, wb_ack;
  logic [31:0] wb_addr, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;

  always #5 clk = ~clk;

  wb_boot_copier #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .src_addr_i(src), .dst_addr_i(dst), .len_i(len),
    .busy_o(busy), .done_o(done), .err_o(err), .words_o(words),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
    .wb_addr_o(wb_addr), .wb_sel_o(wb_sel), .wb_data_o(wb_dat_o),
    .wb_ack_i(wb_ack), .wb_data_i(wb_dat_i)
  );

  // Memory contents are a fixed function of the word address.
  function automatic logic [31:0] rdval(input logic [31:0] a);
    return 32'hA000_0000 + ((a - 32'h0800_0000) >> 2);
  endfunction

  // Slave: acks after `lat` stalled cycles; optional stray acks while idle.
  logic        ack_en, spur_en, spur;
  logic [15:0] lat, scnt;
  logic        slave_ack;
  assign slave_ack = wb_cyc && wb_stb && ack_en && (scnt == lat);
  assign wb_ack    = slave_ack || (spur && !wb_cyc);
  assign wb_dat_i  = (wb_cyc && !wb_we) ? rdval(wb_addr) : 32'hDEAD_BEEF;

  always @(posedge clk or posedge rst) begin
    if (rst) scnt <= '0;
    else if (!wb_cyc || slave_ack) scnt <= '0;
    else scnt <= scnt + 16'd1;
  end

  always @(posedge clk) spur <= spur_en && ($urandom_range(0, 3) == 0);

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} txn_t;
  typedef struct packed {logic [19:0] words; logic err;} cmp_t;
  txn_t tq[$];
  cmp_t cq[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: a copy of n words transfers `k` of them, then completes.
  task automatic model_copy(input logic [31:0] s, input logic [31:0] d,
                            input int unsigned k, input logic e);
    txn_t t;
    cmp_t c;
    logic [31:0] sa, da;
    sa = s & ~32'h3;
    da = d & ~32'h3;
    for (int unsigned i = 0; i < k; i++) begin
      t.we = 1'b0; t.addr = sa + 32'(4 * i); t.data = '0;
      tq.push_back(t);
      t.we = 1'b1; t.addr = da + 32'(4 * i); t.data = rdval(sa + 32'(4 * i));
      tq.push_back(t);
    end
    c.words = 20'(k);
    c.err = e;
    cq.push_back(c);
  endtask

  // Monitor
  logic prev_cyc = 1'b0, prev_err = 1'b0, armed = 1'b0;
  int   idle = 0, rises = 0, wr_acks = 0, dones = 0;
  always @(negedge clk) begin
    txn_t t;
    cmp_t c;
    if (rst) begin
      prev_cyc = 1'b0; prev_err = 1'b0; armed = 1'b0; idle = 0;
    end else begin
      chk("bus_lines", {wb_stb, wb_sel, wb_addr[1:0]},
          wb_cyc ? {1'b1, 4'hF, 2'b00} : 7'b0);
      if (wb_cyc && !prev_cyc) begin
        rises++;
        if (armed) chk("gap_len", 64'(idle), 64'(GAP));
        idle = 0;
      end
      if (!wb_cyc) idle++;
      if (wb_cyc && wb_ack) begin
        if (tq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_txn: got we=%0b addr=%0h, expected no transaction", wb_we, wb_addr);
        end else begin
          t = tq.pop_front();
          chk("txn_we_addr", {wb_we, wb_addr}, {t.we, t.addr});
          if (t.we) chk("wr_data", wb_dat_o, t.data);
        end
        if (wb_we) wr_acks++;
        armed = 1'b1;
      end
      if (!busy) armed = 1'b0;
      if (done) dones++;
      if (done || (err && !prev_err)) begin
        if (cq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_completion: got done=%0b err=%0b, expected none", done, err);
        end else begin
          c = cq.pop_front();
          chk("completion", {words, err}, {c.words, c.err});
          chk("busy_at_end", busy, 0);
        end
      end
      prev_cyc = wb_cyc;
      prev_err = err;
    end
  end

  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [19:0] n);
    src = s; dst = d; len = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (cq.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (cq.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL completion_wait: got no completion in %0d cycles, expected one", maxc);
      cq.delete();
      tq.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0, n, d0;
    logic [31:0] s, d;
    logic [19:0] l;
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    ack_en = 1'b1; lat = 16'd0; spur_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_status", {busy, done, err, words}, '0);
    chk("reset_bus", {wb_cyc, wb_stb, wb_we, wb_sel, wb_addr, wb_dat_o}, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic boot copy
    lat = 16'd1;
    r0 = rises;
    model_copy(32'h0800_0000, 32'h0000_0100, 4, 1'b0);
    do_start(32'h0800_0000, 32'h0000_0100, 20'd4);
    wait_idle(400);
    chk("basic_txn_count", 64'(rises - r0), 64'd8);

    // Zero length
    r0 = rises;
    model_copy(32'h0800_0000, 32'h0000_0200, 0, 1'b0);
    do_start(32'h0800_0000, 32'h0000_0200, 20'd0);
    @(negedge clk);
    chk("len0_cycle1", {busy, done}, 2'b10);
    @(negedge clk);
    chk("len0_cycle2", {busy, done}, 2'b01);
    wait_idle(20);
    chk("len0_no_bus", 64'(rises - r0), 64'd0);

    // Timeout with a dead slave, then recovery
    ack_en = 1'b0;
    model_copy(32'h0800_0010, 32'h0000_0300, 0, 1'b1);
    do_start(32'h0800_0010, 32'h0000_0300, 20'd3);
    n = 0;
    while (!wb_cyc && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    n = 0;
    while (wb_cyc && n < 300) begin n++; @(negedge clk); end
    chk("timeout_stall_cycles", 64'(n), 64'(TO));
    wait_idle(50);
    ack_en = 1'b1; lat = 16'd2;
    model_copy(32'h0800_0020, 32'h0000_0400, 3, 1'b0);
    do_start(32'h0800_0020, 32'h0000_0400, 20'd3);
    @(negedge clk);
    chk("err_cleared_on_start", err, 0);
    wait_idle(400);

    // Ack exactly in the limit cycle, with stray idle acks
    lat = 16'(TO - 1); spur_en = 1'b1;
    model_copy(32'h0800_1000, 32'h0000_0500, 2, 1'b0);
    do_start(32'h0800_1000, 32'h0000_0500, 20'd2);
    wait_idle(800);
    chk("ack_at_limit_err", err, 0);

    // Reset during the third write
    lat = 16'd2; spur_en = 1'b0;
    w0 = wr_acks;
    model_copy(32'h0800_0400, 32'h0000_0600, 8, 1'b0);
    do_start(32'h0800_0400, 32'h0000_0600, 20'd8);
    n = 0;
    do begin @(negedge clk); #1; n++; end
    while (!((wr_acks - w0) == 2 && wb_cyc && wb_we) && n < 200);
    chk("third_write_reached", 64'(wr_acks - w0), 64'd2);
    #1 rst = 1'b1;
    #1;
    chk("reset_async_bus", {wb_cyc, wb_stb, wb_we, wb_sel, wb_addr, wb_dat_o}, '0);
    chk("reset_async_status", {busy, done, err, words}, '0);
    tq.delete();
    cq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    d0 = dones;
    repeat (20) @(posedge clk);
    #1;
    chk("no_done_after_reset", 64'(dones - d0), 64'd0);
    chk("idle_after_reset", {busy, wb_cyc, words}, '0);

    // Start and input changes while busy are ignored
    lat = 16'd1;
    model_copy(32'h0800_0800, 32'h0000_0700, 6, 1'b0);
    do_start(32'h0800_0800, 32'h0000_0700, 20'd6);
    repeat (7) @(posedge clk);
    #1;
    do_start($urandom, $urandom, 20'd3);
    wait_idle(600);
    repeat (10) @(posedge clk);
    #1;
    chk("ignored_start_no_txn", 64'(tq.size()), 64'd0);

    // Source address wraps through zero
    lat = 16'd0;
    model_copy(32'hFFFF_FFFC, 32'h0000_0800, 2, 1'b0);
    do_start(32'hFFFF_FFFC, 32'h0000_0800, 20'd2);
    wait_idle(200);

    // Random copies
    for (int k = 0; k < 8; k++) begin
      s = $urandom; d = $urandom; l = 20'($urandom_range(1, 6));
      lat = 16'($urandom_range(0, 4));
      spur_en = 1'($urandom_range(0, 1));
      model_copy(s, d, int'(l), 1'b0);
      do_start(s, d, l);
      wait_idle(600);
    end

    chk("leftover_txn", 64'(tq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
